// File: rtl/snake_pkg.sv
// Direction codes shared by the snake input stage and the game logic.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
//
// Contents: dir_t, DIR_* codes, opposite() for 180-degree reversal checks.
package snake_pkg;

    typedef logic [2:0] dir_t;

    localparam dir_t DIR_IDLE  = 3'd0;
    localparam dir_t DIR_UP    = 3'd1;
    localparam dir_t DIR_DOWN  = 3'd2;
    localparam dir_t DIR_LEFT  = 3'd3;
    localparam dir_t DIR_RIGHT = 3'd4;

    // Reversed heading; idle (and any unused code) maps to idle.
    function automatic dir_t opposite(input dir_t d);
        dir_t r;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
            default:   r = DIR_IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, stability counter, rising-edge press pulse.
// Latency: press_o rises 2 + DEBOUNCE_CYCLES cycles after a stable raw rising edge.
// Backpressure: none; press_o is a single-cycle event that is never held.
//
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   btn_i   raw asynchronous button level, active-high
//   press_o one-cycle pulse when the debounced level goes 0 -> 1
module btn_debounce
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // The counter only advances while the synchronised level disagrees with
    // the debounced one; any agreement (e.g. a bounce back) restarts it.
    always_comb begin
        cnt_d   = '0;
        deb_d   = deb_q;
        press_d = 1'b0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d   = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake input stage: debounced buttons -> pending direction -> committed accion on each move tick.
// Latency: press reaches pending 3 + DEBOUNCE_CYCLES cycles after a raw edge; accion commits on tick, mover one cycle later.
// Backpressure: none; the consumer samples accion when mover is high, code 0 means no move.
//
// Ports:
//   uclk                                 system clock
//   reset                                asynchronous active-low reset
//   BtnLeft/BtnRight/BtnTop/BtnBottom    raw asynchronous buttons, active-high
//   accion                               committed direction (0 idle, 1 up, 2 down, 3 left, 4 right)
//   mover                                one-cycle step pulse, follows the commit by one cycle
// Build option: define SNAKE_SPEEDUP_EN to shorten the move period as the snake keeps moving.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MOVE_PERIOD     = 5000000,
    parameter int MIN_PERIOD      = 1000000,
    parameter int SPEED_STEP      = 500000,
    parameter int MOVES_PER_LEVEL = 16
) (
    input  logic uclk,
    input  logic reset,
    input  logic BtnLeft,
    input  logic BtnRight,
    input  logic BtnTop,
    input  logic BtnBottom,
    output dir_t accion,
    output logic mover
);

    localparam int CNT_W    = $clog2(MOVE_PERIOD);
    localparam int STEP_SAF = (SPEED_STEP > 0) ? SPEED_STEP : 1;
    localparam int LVL_MAX  = (MOVE_PERIOD - MIN_PERIOD + STEP_SAF - 1) / STEP_SAF;
    // One width serves both the speed level and the per-level tick count.
    localparam int SPD_MAX  = (LVL_MAX > MOVES_PER_LEVEL) ? LVL_MAX : MOVES_PER_LEVEL;
    localparam int SPD_W    = $clog2(SPD_MAX + 1);

    // Last count value of a period at the given speed level.
    function automatic logic [CNT_W-1:0] period_last(input logic [SPD_W-1:0] lvl);
        int dec;
        dec = int'(lvl) * SPEED_STEP;
        if (dec >= MOVE_PERIOD - MIN_PERIOD) begin
            return CNT_W'(MIN_PERIOD - 1);
        end
        return CNT_W'(MOVE_PERIOD - dec - 1);
    endfunction

    // ------------------------------------------------------------------
    // Button front-end
    // ------------------------------------------------------------------
    logic press_top, press_bottom, press_left, press_right;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_top (
        .clk_i(uclk), .rst_ni(reset), .btn_i(BtnTop),    .press_o(press_top)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_bottom (
        .clk_i(uclk), .rst_ni(reset), .btn_i(BtnBottom), .press_o(press_bottom)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk_i(uclk), .rst_ni(reset), .btn_i(BtnLeft),   .press_o(press_left)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk_i(uclk), .rst_ni(reset), .btn_i(BtnRight),  .press_o(press_right)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    dir_t             accion_q, accion_d;
    dir_t             pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             mover_q, mover_d;
    logic [SPD_W-1:0] level;
    logic [CNT_W-1:0] period_m1;
    logic             tick;
    dir_t             press_code;

    assign period_m1 = period_last(level);
    assign tick      = (cnt_q == period_m1);

    // Fixed priority: only the highest-ranked simultaneous press is seen.
    always_comb begin
        press_code = DIR_IDLE;
        if (press_top)         press_code = DIR_UP;
        else if (press_bottom) press_code = DIR_DOWN;
        else if (press_left)   press_code = DIR_LEFT;
        else if (press_right)  press_code = DIR_RIGHT;
    end

    // Reversal is judged against the committed heading, so a quick
    // perpendicular-then-reverse sequence inside one period cannot fold the
    // snake back on itself. A press on the tick edge still sees the old accion.
    always_comb begin
        pending_d = pending_q;
        if (press_code != DIR_IDLE &&
            !(accion_q != DIR_IDLE && press_code == opposite(accion_q))) begin
            pending_d = press_code;
        end

        cnt_d    = cnt_q + 1'b1;
        accion_d = accion_q;
        tick_d   = tick;
        mover_d  = tick_q;
        if (tick) begin
            cnt_d    = '0;
            accion_d = pending_q;
        end
    end

    always_ff @(posedge uclk or negedge reset) begin
        if (!reset) begin
            accion_q  <= DIR_IDLE;
            pending_q <= DIR_IDLE;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            mover_q   <= 1'b0;
        end else begin
            accion_q  <= accion_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            mover_q   <= mover_d;
        end
    end

    // ------------------------------------------------------------------
    // Speed level
    // ------------------------------------------------------------------
`ifdef SNAKE_SPEEDUP_EN
    logic [SPD_W-1:0] level_q, level_d;
    logic [SPD_W-1:0] moves_q, moves_d;

    // Only ticks taken while actually moving count. The level changes on a
    // tick edge, when the counter has just wrapped, so a period is never cut.
    always_comb begin
        level_d = level_q;
        moves_d = moves_q;
        if (tick && accion_q != DIR_IDLE) begin
            if (moves_q == SPD_W'(MOVES_PER_LEVEL - 1)) begin
                moves_d = '0;
                if (period_m1 > CNT_W'(MIN_PERIOD - 1)) begin
                    level_d = level_q + 1'b1;
                end
            end else begin
                moves_d = moves_q + 1'b1;
            end
        end
    end

    always_ff @(posedge uclk or negedge reset) begin
        if (!reset) begin
            level_q <= '0;
            moves_q <= '0;
        end else begin
            level_q <= level_d;
            moves_q <= moves_d;
        end
    end

    assign level = level_q;
`else
    // Fixed speed: the period stays at MOVE_PERIOD.
    assign level = '0;
`endif

    assign accion = accion_q;
    assign mover  = mover_q;

endmodule
